mul_hilo_unit: RTL and testbench
================================

// Module: mul_hilo_unit
// PURPOSE
//   Multicycle MULT/MULTU execution unit with the HI/LO result registers for the CPU core.
//   Takes two WIDTH-bit operands from the execute stage and runs a radix-2 shift-add over WIDTH cycles.
//   Writes the 2*WIDTH product into HI (upper half) and LO (lower half) for later MFHI/MFLO reads.
//   Also provides the direct HI/LO writes used by MTHI/MTLO.
// PARAMETERS
//   WIDTH  32  operand width; product is 2*WIDTH; HI and LO are WIDTH bits each
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      launch a multiply (sampled only in IDLE)
//   is_signed  in   1      1 = MULT (two's complement), 0 = MULTU; sampled with start
//   op_a       in   WIDTH  multiplicand; sampled with start
//   op_b       in   WIDTH  multiplier; sampled with start
//   hi_we      in   1      MTHI write enable
//   lo_we      in   1      MTLO write enable
//   wdata      in   WIDTH  data for MTHI/MTLO
//   busy       out  1      high while a multiply is in flight (RUN or DONE)
//   done       out  1      one-cycle pulse; HI/LO hold the new product in this cycle
//   hi         out  WIDTH  HI register, product[2W-1:W]
//   lo         out  WIDTH  LO register, product[W-1:0]
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; internal accum/count cleared.
//   States:
//     IDLE: start=1 -> RUN.
//       Latches |op_a|, |op_b|, neg = is_signed & (op_a[W-1]^op_b[W-1]), count=WIDTH, accum=0.
//       Absolute value applies only when is_signed=1.
//     RUN: each cycle, if multiplier[0], upper accum += multiplicand (W+1-bit add, carry kept).
//       Then shift {carry, accum, multiplier} right by 1 and decrement count.
//       At count==1 the final step runs and the state -> DONE.
//     DONE: product P = neg ? -accum : accum (2W-bit two's complement).
//       {hi,lo} <= P on entry edge; done=1 for exactly this cycle; -> IDLE next edge.
//   Latency: start sampled at edge t -> RUN for WIDTH cycles -> done=1 and hi/lo updated in cycle t+WIDTH+1.
//     Next start is accepted at edge t+WIDTH+2.
//   busy: 1 in RUN and DONE, 0 in IDLE; combinational from the state register.
//   start while busy: ignored; no queuing and no effect on the running operation.
//   hi_we/lo_we: honoured only in IDLE; hi<=wdata / lo<=wdata on the edge; both may be set together.
//     Ignored while busy, so MTHI/MTLO cannot corrupt an in-flight product.
//   start together with hi_we/lo_we in IDLE: the write takes effect now; the product overwrites it at DONE.
//   Width rules: the most negative operand (0x80000000 at W=32) has |x|=2^(W-1), which fits in W unsigned bits.
//     No overflow is possible; the 2W-bit product is always exact.
//   rst_n low mid-operation: aborts immediately; hi/lo=0; no done pulse; IDLE on release.
//   Outputs hi/lo hold their value between updates; done is never asserted outside DONE.
// TESTING
//   1 MULTU 9 x 12 -> done at start+33 cycles; hi=0x00000000, lo=0x0000006C; busy low next cycle.
//   2 MULTU 0xFFFFFFFE x 0xFFFFFFFE -> hi=0xFFFFFFFC, lo=0x00000004.
//     MULT on the same operands -> hi=0x00000000, lo=0x00000004.
//   3 MULT 0xFFFFFFFE x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//     MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
//   4 Start 9x12; pulse start with 5x5 and hi_we with wdata=0xDEAD at cycle 10.
//     -> both ignored; final hi=0, lo=0x6C; exactly one done pulse.
//   5 IDLE: hi_we=1, lo_we=1, wdata=0x12345678 -> hi=lo=0x12345678 next cycle; start 2x2 -> lo=4, hi=0.
//   6 Start 7x7; drop rst_n at cycle 15 -> busy=0, hi=lo=0, no done.
//     Release; start 7x7 -> lo=0x31 after 33 cycles.

Source files
------------

// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - multicycle MULT/MULTU unit with HI/LO result registers
//
// Radix-2 shift-add multiplier. A launched multiply runs WIDTH iterations. The
// final iteration's 2*WIDTH product is written into HI/LO on the same edge that
// enters DONE. Signed operands are reduced to magnitudes up front. The sign is
// restored on that final write.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      launch a multiply (sampled only in IDLE)
//   is_signed  1 = MULT (two's complement), 0 = MULTU; sampled with start
//   op_a       multiplicand; sampled with start
//   op_b       multiplier; sampled with start
//   hi_we      MTHI write enable (IDLE only)
//   lo_we      MTLO write enable (IDLE only)
//   wdata      data for MTHI/MTLO
//   busy       high in RUN and DONE
//   done       one-cycle pulse; HI/LO hold the new product in this cycle
//   hi         HI register, product[2W-1:W]
//   lo         LO register, product[W-1:0]
module mul_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] accum;
    logic [CW-1:0]    count;
    logic             neg;

    // Magnitudes of the operands. The most negative value negates to itself,
    // which read as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        abs_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
        abs_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    end

    // One shift-add iteration. The add is WIDTH+1 bits wide so the carry
    // shifts down into the top of the accumulator instead of being lost.
    logic [WIDTH:0]     step_sum;
    logic [WIDTH-1:0]   accum_nxt;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_final;

    always_comb begin
        step_sum   = {1'b0, accum} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        accum_nxt  = step_sum[WIDTH:1];
        mplier_nxt = {step_sum[0], mplier[WIDTH-1:1]};
        prod_mag   = {accum_nxt, mplier_nxt};
        prod_final = neg ? (~prod_mag + 1'b1) : prod_mag;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            accum  <= '0;
            count  <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Register moves land now. A multiply launched on the same
                    // edge overwrites them when it completes.
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        mcand  <= abs_a;
                        mplier <= abs_b;
                        accum  <= '0;
                        neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        count  <= CW'(WIDTH);
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    accum  <= accum_nxt;
                    mplier <= mplier_nxt;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        hi    <= prod_final[2*WIDTH-1:WIDTH];
                        lo    <= prod_final[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    accum <= '0;
                    count <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - self-checking bench for mul_hilo_unit
module tb_mul_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_hilo_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference product from plain wide arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Launch one multiply; returns the number of clock edges after the start
    // edge at which done was first observed (-1 if never within the budget).
    // Returns positioned at the negedge in which done is high.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; is_signed = s;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    vec_t vecs[8];
    int   lat;
    int   dones;
    logic [63:0] exp64;

    initial begin
        vecs[0] = '{32'd9,        32'd12,       1'b0, 32'h00000000, 32'h0000006C};
        vecs[1] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFC, 32'h00000004};
        vecs[2] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1, 32'h00000000, 32'h00000004};
        vecs[3] = '{32'hFFFFFFFE, 32'd3,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        vecs[5] = '{32'h80000000, 32'd1,        1'b1, 32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[7] = '{32'd0,        32'hDEADBEEF, 1'b1, 32'h00000000, 32'h00000000};

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].s, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i), {busy, done}, 64'd0);
        end

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 5 == 0) a = {1'b1, 31'($urandom_range(0, 3))};
            exp64 = ref_mul(a, b, s);
            run_mul(a, b, s, lat);
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd32);
            chk($sformatf("rnd%0d_prod a=%h b=%h s=%0d", i, a, b, s), {hi, lo}, exp64);
            @(negedge clk);
        end

        // Start and MTHI while a multiply is running are both ignored.
        @(negedge clk);
        start = 1'b1; op_a = 32'd9; op_b = 32'd12; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 10) begin
                start = 1'b1; op_a = 32'd5; op_b = 32'd5; hi_we = 1'b1; wdata = 32'hDEAD;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            if (done) dones++;
        end
        chk("busy_ignore_hi", 64'(hi), 64'd0);
        chk("busy_ignore_lo", 64'(lo), 64'h6C);
        chk("busy_ignore_done_count", 64'(dones), 64'd1);

        // MTHI/MTLO together in IDLE, then a product overwrites them.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_hi", 64'(hi), 64'h12345678);
        chk("mt_lo", 64'(lo), 64'h12345678);
        run_mul(32'd2, 32'd2, 1'b0, lat);
        chk("mt_then_mul_hi", 64'(hi), 64'd0);
        chk("mt_then_mul_lo", 64'(lo), 64'd4);
        @(negedge clk);

        // Reset mid-operation aborts with no done pulse.
        start = 1'b1; op_a = 32'd7; op_b = 32'd7; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi",   64'(hi),   64'd0);
        chk("abort_lo",   64'(lo),   64'd0);
        dones = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 35; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        run_mul(32'd7, 32'd7, 1'b0, lat);
        chk("after_abort_latency", 64'(lat), 64'd32);
        chk("after_abort_lo", 64'(lo), 64'h31);
        chk("after_abort_hi", 64'(hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
